// File: rtl/edge_scan_ctrl_pkg.sv
// Shared constants, types and helpers for the edge scan controller.
//
// Contents:
//   MAX_NODES, NODE_WIDTH, EDGE_W, MAX_EDGES, CNT_W  geometry of the scan
//   GRAPH_W, GRAPH_IDX_W                             adjacency vector width / bit index width
//   state_t                                          controller states IDLE/SCAN/EMIT/DONE
//   pack_edge()                                      builds an edge word {row, col, weight=0}
//   clamp_nodes()                                    limits a node count to MAX_NODES
package edge_scan_ctrl_pkg;

   localparam int MAX_NODES   = 16;
   localparam int NODE_WIDTH  = 4;
   localparam int EDGE_W      = 3 * NODE_WIDTH;
   localparam int MAX_EDGES   = 64;
   localparam int CNT_W       = 7;
   localparam int GRAPH_W     = MAX_NODES * MAX_NODES;
   localparam int GRAPH_IDX_W = $clog2(GRAPH_W);

   typedef logic [NODE_WIDTH-1:0] node_t;   // row or column index
   typedef logic [NODE_WIDTH:0]   qnode_t;  // node count, 0..MAX_NODES inclusive
   typedef logic [EDGE_W-1:0]     edge_t;
   typedef logic [CNT_W-1:0]      cnt_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } state_t;

   // Edge word layout {row, col, weight}; the weight field is always zero here.
   function automatic edge_t pack_edge(input node_t row, input node_t col);
      return {row, col, {NODE_WIDTH{1'b0}}};
   endfunction

   function automatic qnode_t clamp_nodes(input qnode_t n);
      return (n > qnode_t'(MAX_NODES)) ? qnode_t'(MAX_NODES) : n;
   endfunction

endpackage

// File: rtl/edge_scan_ctrl_if.sv
// Bus bundle between the scan requester / edge-list store and the controller.
//
// Signals:
//   start, abort        scan request and cancel
//   num_nodes           active node count
//   graph_in            adjacency matrix, bit 0 is the MSB (cell 0 is graph_in[GRAPH_W-1])
//   edge_valid/ready    edge word handshake towards the edge-list store
//   edge_data, edge_idx edge word and its slot index
//   edge_count          edges accepted in the last or current scan
//   busy, done          scan in progress / one-cycle completion pulse
//   overflow            sticky: a set bit was found with the edge list full
//
// Modports:
//   master  the requester side (drives start/abort/graph, accepts edges)
//   slave   the controller
interface edge_scan_ctrl_if;
   import edge_scan_ctrl_pkg::*;

   logic               start;
   logic               abort;
   qnode_t             num_nodes;
   logic [GRAPH_W-1:0] graph_in;
   logic               edge_valid;
   logic               edge_ready;
   edge_t              edge_data;
   cnt_t               edge_idx;
   cnt_t               edge_count;
   logic               busy;
   logic               done;
   logic               overflow;

   modport master (
      output start, abort, num_nodes, graph_in, edge_ready,
      input  edge_valid, edge_data, edge_idx, edge_count, busy, done, overflow
   );

   modport slave (
      input  start, abort, num_nodes, graph_in, edge_ready,
      output edge_valid, edge_data, edge_idx, edge_count, busy, done, overflow
   );

endinterface

// File: rtl/edge_scan_ctrl_tri_index_counter.sv
// Lower-triangle walker: produces the (row, col) cell sequence
// (1,0), (2,0), (2,1), (3,0), ... one step per advance.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   init        load the first cell (1,0)
//   advance     step to the next cell
//   num_nodes   active node count of the current scan (>= 2 while walking)
//   row, col    current cell
//   last        current cell is the final one; advancing from it ends the scan
module tri_index_counter
   import edge_scan_ctrl_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   init,
   input  logic   advance,
   input  qnode_t num_nodes,
   output node_t  row,
   output node_t  col,
   output logic   last
);

   logic   row_end;
   qnode_t next_row;

   // The row ends at the cell just left of the diagonal.
   assign row_end  = (col == row - node_t'(1));
   assign next_row = {1'b0, row} + qnode_t'(1);
   assign last     = row_end && (next_row == num_nodes);

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
      end else if (init) begin
         row <= node_t'(1);
         col <= '0;
      end else if (advance) begin
         if (row_end) begin
            row <= row + node_t'(1);
            col <= '0;
         end else begin
            col <= col + node_t'(1);
         end
      end
   end

endmodule

// File: rtl/edge_scan_ctrl.sv
// Stallable lower-triangle edge extractor. On start it snapshots the adjacency
// matrix and node count, then examines one strictly-lower cell per clock. Every
// set bit becomes one edge word {row, col, 0} offered on a valid/ready
// handshake, with its slot index. The scan stops early with a sticky overflow
// flag if another edge is found while the edge list is already full.
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    edge_scan_ctrl_if.slave (start/abort/num_nodes/graph_in in,
//          edge handshake, edge_count, busy, done, overflow out)
module edge_scan_ctrl (
   input  logic              clk,
   input  logic              rst_n,
   edge_scan_ctrl_if.slave   bus
);
   import edge_scan_ctrl_pkg::*;

   state_t                 state_q;
   state_t                 state_d;

   logic [GRAPH_W-1:0]     graph_q;    // snapshot, stored bit-reversed so cell k is graph_q[k]
   qnode_t                 nodes_q;
   cnt_t                   count_q;
   cnt_t                   idx_q;
   edge_t                  data_q;
   logic                   ovf_q;

   node_t                  row;
   node_t                  col;
   logic                   last_cell;
   logic [GRAPH_IDX_W-1:0] cell_idx;
   logic                   cell_bit;
   qnode_t                 nodes_clamped;

   logic                   snap_load;
   logic                   walk_init;
   logic                   walk_adv;
   logic                   edge_load;
   logic                   count_clr;
   logic                   count_inc;
   logic                   ovf_set;

   assign nodes_clamped = clamp_nodes(bus.num_nodes);
   assign cell_idx      = GRAPH_IDX_W'(row) * GRAPH_IDX_W'(MAX_NODES) + GRAPH_IDX_W'(col);
   assign cell_bit      = graph_q[cell_idx];

   tri_index_counter u_walk (
      .clk       (clk),
      .rst_n     (rst_n),
      .init      (walk_init),
      .advance   (walk_adv),
      .num_nodes (nodes_q),
      .row       (row),
      .col       (col),
      .last      (last_cell)
   );

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ------------------------------------------------------------------
   // Next state and datapath strobes. Abort overrides everything,
   // including a handshake in the same cycle.
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d   = state_q;
      snap_load = 1'b0;
      walk_init = 1'b0;
      walk_adv  = 1'b0;
      edge_load = 1'b0;
      count_clr = 1'b0;
      count_inc = 1'b0;
      ovf_set   = 1'b0;

      if (bus.abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  snap_load = 1'b1;
                  walk_init = 1'b1;
                  count_clr = 1'b1;
                  state_d   = (nodes_clamped < qnode_t'(2)) ? DONE : SCAN;
               end
            end

            SCAN: begin
               if (cell_bit) begin
                  if (count_q < cnt_t'(MAX_EDGES)) begin
                     edge_load = 1'b1;
                     state_d   = EMIT;
                  end else begin
                     ovf_set = 1'b1;
                     state_d = DONE;
                  end
               end else begin
                  walk_adv = 1'b1;
                  if (last_cell) state_d = DONE;
               end
            end

            EMIT: begin
               if (bus.edge_ready) begin
                  count_inc = 1'b1;
                  walk_adv  = 1'b1;
                  state_d   = last_cell ? DONE : SCAN;
               end
            end

            DONE: state_d = IDLE;

            default: state_d = IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nodes_q <= '0;
         count_q <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (snap_load) nodes_q <= nodes_clamped;

         if (count_clr)      count_q <= '0;
         else if (count_inc) count_q <= count_q + cnt_t'(1);

         if (count_clr)    ovf_q <= 1'b0;
         else if (ovf_set) ovf_q <= 1'b1;

         // Word and slot index stay frozen while EMIT waits for ready.
         if (edge_load) begin
            data_q <= pack_edge(row, col);
            idx_q  <= count_q;
         end
      end
   end

   // NOTE: the matrix snapshot has no reset; it is always loaded on start
   // before any cell of it is examined, so its power-up contents never matter.
   always_ff @(posedge clk) begin
      if (snap_load) graph_q <= {<<{bus.graph_in}};
   end

   // ------------------------------------------------------------------
   // Outputs decoded from registered state
   // ------------------------------------------------------------------
   assign bus.edge_valid = (state_q == EMIT);
   assign bus.busy       = (state_q == SCAN) || (state_q == EMIT);
   assign bus.done       = (state_q == DONE);
   assign bus.edge_data  = data_q;
   assign bus.edge_idx   = idx_q;
   assign bus.edge_count = count_q;
   assign bus.overflow   = ovf_q;

endmodule
